// File: rtl/axis_video_frame_checker_if.sv
// AXI4-Stream RGB888 video bus: tdata = {B,G,R}, tuser = start of frame, tlast = end of line.
// A beat transfers on a rising clock edge where tvalid and tready are both high; the master holds
// tdata/tuser/tlast stable while tvalid is high and tready is low, and tready may toggle freely.
interface axis_video_frame_checker_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_video_frame_checker.sv
// Video stream sink: checks line/frame geometry and SOF placement, accumulates a per-frame
// R+G+B checksum and counts completed frames. Optional deterministic backpressure on tready.
module axis_video_frame_checker #(
  parameter int g_H_RES         = 960,
  parameter int g_V_RES         = 2160,
  parameter int g_READY_PATTERN = 0,
  parameter int g_STALL_PERIOD  = 8
) (
  input  logic                  sys_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  axis_video_frame_checker_if.slave s_axis,
  output logic                  frame_done_o,
  output logic [15:0]           frame_count_o,
  output logic [31:0]           pixel_sum_o,
  output logic [15:0]           x_o,
  output logic [15:0]           y_o,
  output logic                  line_err_o,
  output logic                  frame_err_o,
  output logic                  sof_err_o,
  output logic                  state_o
);

  localparam int          CW         = $clog2(g_STALL_PERIOD);
  localparam logic [15:0] H_LAST     = 16'(g_H_RES - 1);
  localparam logic [15:0] V_LAST     = 16'(g_V_RES - 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(g_STALL_PERIOD - 1);

  typedef enum logic {ST_WAIT_SOF = 1'b0, ST_ACTIVE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [31:0]   sum_q, sum_d, pixel_sum_q, pix_val;
  logic [15:0]   count_q;
  logic [CW-1:0] stall_cnt_q;
  logic          tready_q, stall, accept;
  logic          done_q, done_d;
  logic          since_q, since_d;
  logic          line_err_q, frame_err_q, sof_err_q;
  logic          line_set, frame_set, sof_set;

  assign stall   = (g_READY_PATTERN == 1) && (stall_cnt_q == STALL_LAST);
  assign accept  = s_axis.tvalid & tready_q;
  assign pix_val = {24'd0, s_axis.tdata[7:0]} + {24'd0, s_axis.tdata[15:8]}
                 + {24'd0, s_axis.tdata[23:16]};

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) state_q <= ST_WAIT_SOF;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sum_d     = sum_q;
    since_d   = since_q;
    done_d    = 1'b0;
    line_set  = 1'b0;
    frame_set = 1'b0;
    sof_set   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_WAIT_SOF: begin
          if (s_axis.tuser) begin
            state_d = ST_ACTIVE;
            x_d     = 16'd1;
            y_d     = 16'd0;
            sum_d   = pix_val;
            since_d = 1'b0;
          end else if (since_q) begin
            // Stray beats after a completed frame mean the source sent too many lines.
            frame_set = 1'b1;
            since_d   = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (s_axis.tuser) begin
            sof_set   = 1'b1;
            frame_set = 1'b1;
            x_d       = 16'd1;
            y_d       = 16'd0;
            sum_d     = pix_val;
          end else begin
            sum_d = sum_q + pix_val;
            if (s_axis.tlast) begin
              line_set = (x_q != H_LAST);
              x_d      = 16'd0;
              if (y_q == V_LAST) begin
                done_d  = 1'b1;
                since_d = 1'b1;
                y_d     = 16'd0;
                state_d = ST_WAIT_SOF;
              end else begin
                y_d = y_q + 16'd1;
              end
            end else begin
              line_set = (x_q == H_LAST);
              x_d      = (x_q == 16'hFFFF) ? x_q : x_q + 16'd1;
            end
          end
        end
        default: state_d = ST_WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      pixel_sum_q <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      since_q     <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      sum_q       <= sum_d;
      since_q     <= since_d;
      done_q      <= done_d;
      stall_cnt_q <= (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + 1'b1;
      tready_q    <= enable_i & ~stall;
      if (done_d) pixel_sum_q <= sum_d;
      // A frame completing in the same cycle as clear still counts.
      count_q     <= clear_i ? {15'd0, done_d} : count_q + {15'd0, done_d};
      line_err_q  <= (line_err_q  & ~clear_i) | line_set;
      frame_err_q <= (frame_err_q & ~clear_i) | frame_set;
      sof_err_q   <= (sof_err_q   & ~clear_i) | sof_set;
    end
  end

  assign s_axis.tready = tready_q;
  assign frame_done_o  = done_q;
  assign frame_count_o = count_q;
  assign pixel_sum_o   = pixel_sum_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_err_o    = line_err_q;
  assign frame_err_o   = frame_err_q;
  assign sof_err_o     = sof_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// Directed bench for axis_video_frame_checker: dut0 runs without backpressure, dut1 with a
// 1-in-4 stall pattern; both use an 8x4 frame so expected sums and counts are easy to derive.
module tb_axis_video_frame_checker;

  logic sys_clk = 1'b0;
  logic reset_i = 1'b1;
  logic enable_i = 1'b1;
  logic clear_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  axis_video_frame_checker_if if0();
  axis_video_frame_checker_if if1();

  logic        done0, done1, lerr0, lerr1, ferr0, ferr1, serr0, serr1, st0, st1;
  logic [15:0] cnt0, cnt1, x0, x1, y0, y1;
  logic [31:0] sum0, sum1;

  axis_video_frame_checker #(.g_H_RES(8), .g_V_RES(4), .g_READY_PATTERN(0), .g_STALL_PERIOD(8)) dut0 (
    .sys_clk_i(sys_clk), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .s_axis(if0.slave), .frame_done_o(done0), .frame_count_o(cnt0), .pixel_sum_o(sum0),
    .x_o(x0), .y_o(y0), .line_err_o(lerr0), .frame_err_o(ferr0), .sof_err_o(serr0), .state_o(st0));

  axis_video_frame_checker #(.g_H_RES(8), .g_V_RES(4), .g_READY_PATTERN(1), .g_STALL_PERIOD(4)) dut1 (
    .sys_clk_i(sys_clk), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .s_axis(if1.slave), .frame_done_o(done1), .frame_count_o(cnt1), .pixel_sum_o(sum1),
    .x_o(x1), .y_o(y1), .line_err_o(lerr1), .frame_err_o(ferr1), .sof_err_o(serr1), .state_o(st1));

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic v, input logic [23:0] d, input logic u, input logic l);
    if (sel == 0) begin
      if0.tvalid = v; if0.tdata = d; if0.tuser = u; if0.tlast = l;
    end else begin
      if1.tvalid = v; if1.tdata = d; if1.tuser = u; if1.tlast = l;
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input int sel, input logic [23:0] d, input logic u, input logic l);
    int waits = 0;
    drive(sel, 1'b1, d, u, l);
    while (((sel == 0) ? if0.tready : if1.tready) !== 1'b1 && waits < 100) begin
      tick();
      waits++;
    end
    if (waits >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout dut%0d tready=0 required=1", sel);
    end else begin
      tick();
    end
    drive(sel, 1'b0, 24'd0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b1;
    enable_i = 1'b1;
    repeat (3) tick();
    vectors++; if (if0.tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready0 got=%b exp=0", if0.tready); end
    vectors++; if (if1.tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready1 got=%b exp=0", if1.tready); end
    vectors++; if ({x0, y0, cnt0} !== 48'd0) begin miscompares++; $display("FAIL reset_xy_cnt got=%h exp=0", {x0, y0, cnt0}); end
    vectors++; if (sum0 !== 32'd0) begin miscompares++; $display("FAIL reset_sum got=%h exp=0", sum0); end
    vectors++; if ({done0, lerr0, ferr0, serr0, st0} !== 5'd0) begin miscompares++; $display("FAIL reset_flags got=%b exp=00000", {done0, lerr0, ferr0, serr0, st0}); end
    reset_i = 1'b0;
    vectors++; if (if0.tready !== 1'b0) begin miscompares++; $display("FAIL tready_before_edge got=%b exp=0", if0.tready); end
    tick();
    vectors++; if ({if0.tready, if1.tready} !== 2'b11) begin miscompares++; $display("FAIL tready_rise got=%b exp=11", {if0.tready, if1.tready}); end
  endtask

  task automatic test_clean_frame();
    int d0 = done_cnt0;
    for (int i = 0; i < 32; i++) begin
      if (i == 19) begin
        vectors++; if ({x0, y0} !== {16'd3, 16'd2}) begin miscompares++; $display("FAIL pre_pause_xy got=%0d,%0d exp=3,2", x0, y0); end
        enable_i = 1'b0;
        tick();
        vectors++; if (if0.tready !== 1'b0) begin miscompares++; $display("FAIL pause_tready got=%b exp=0", if0.tready); end
        drive(0, 1'b1, 24'h010203, 1'b0, 1'b0);
        repeat (3) tick();
        vectors++; if ({x0, y0} !== {16'd3, 16'd2}) begin miscompares++; $display("FAIL pause_xy got=%0d,%0d exp=3,2", x0, y0); end
        enable_i = 1'b1;
      end
      send_beat(0, 24'h010203, i == 0, (i % 8) == 7);
      if (i == 0) begin
        vectors++; if ({st0, x0, y0} !== {1'b1, 16'd1, 16'd0}) begin miscompares++; $display("FAIL sof_start got=%b,%0d,%0d exp=1,1,0", st0, x0, y0); end
      end
      if (i == 7) begin
        vectors++; if ({x0, y0} !== {16'd0, 16'd1}) begin miscompares++; $display("FAIL first_eol got=%0d,%0d exp=0,1", x0, y0); end
      end
    end
    vectors++; if (done0 !== 1'b1) begin miscompares++; $display("FAIL clean_done got=%b exp=1", done0); end
    vectors++; if (cnt0 !== 16'd1) begin miscompares++; $display("FAIL clean_count got=%0d exp=1", cnt0); end
    vectors++; if (sum0 !== 32'd192) begin miscompares++; $display("FAIL clean_sum got=%0d exp=192", sum0); end
    vectors++; if ({lerr0, ferr0, serr0, st0, x0, y0} !== 36'd0) begin miscompares++; $display("FAIL clean_state got=%b,%b,%b,%b,%0d,%0d exp=all0", lerr0, ferr0, serr0, st0, x0, y0); end
    tick();
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL clean_done_pulse got=%b exp=0", done0); end
    vectors++; if (done_cnt0 - d0 !== 1) begin miscompares++; $display("FAIL clean_done_count got=%0d exp=1", done_cnt0 - d0); end
  endtask

  task automatic test_bubbles_backpressure();
    int lows0 = 0, lows1 = 0, consec = 0;
    int d1 = done_cnt1;
    logic prev = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!if0.tready) lows0++;
      if (!if1.tready) lows1++;
      if (!if1.tready && !prev) consec++;
      prev = if1.tready;
    end
    vectors++; if (lows1 !== 4) begin miscompares++; $display("FAIL stall_lows got=%0d exp=4", lows1); end
    vectors++; if (consec !== 0) begin miscompares++; $display("FAIL stall_consecutive got=%0d exp=0", consec); end
    vectors++; if (lows0 !== 0) begin miscompares++; $display("FAIL nostall_lows got=%0d exp=0", lows0); end
    for (int i = 0; i < 32; i++) begin
      send_beat(1, 24'h010203, i == 0, (i % 8) == 7);
      if (i == 3) repeat (5) tick();
    end
    vectors++; if (cnt1 !== 16'd1) begin miscompares++; $display("FAIL bp_count got=%0d exp=1", cnt1); end
    vectors++; if (sum1 !== 32'd192) begin miscompares++; $display("FAIL bp_sum got=%0d exp=192", sum1); end
    vectors++; if ({lerr1, ferr1, serr1} !== 3'b000) begin miscompares++; $display("FAIL bp_errors got=%b exp=000", {lerr1, ferr1, serr1}); end
    tick();
    vectors++; if (done_cnt1 - d1 !== 1) begin miscompares++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt1 - d1); end
  endtask

  task automatic test_early_tlast();
    int d0 = done_cnt0;
    for (int i = 0; i < 8; i++) send_beat(0, 24'h80FF10, i == 0, i == 7);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        vectors++; if (lerr0 !== 1'b0) begin miscompares++; $display("FAIL pre_early_lerr got=%b exp=0", lerr0); end
      end
      send_beat(0, 24'h80FF10, 1'b0, i == 5);
    end
    vectors++; if ({lerr0, x0, y0} !== {1'b1, 16'd0, 16'd2}) begin miscompares++; $display("FAIL early_tlast got=%b,%0d,%0d exp=1,0,2", lerr0, x0, y0); end
    for (int i = 0; i < 16; i++) send_beat(0, 24'h80FF10, 1'b0, (i % 8) == 7);
    vectors++; if (cnt0 !== 16'd2) begin miscompares++; $display("FAIL early_count got=%0d exp=2", cnt0); end
    vectors++; if (sum0 !== 32'd11970) begin miscompares++; $display("FAIL early_sum got=%0d exp=11970", sum0); end
    vectors++; if ({ferr0, serr0} !== 2'b00) begin miscompares++; $display("FAIL early_other_errs got=%b exp=00", {ferr0, serr0}); end
    tick();
    vectors++; if (done_cnt0 - d0 !== 1) begin miscompares++; $display("FAIL early_done_count got=%0d exp=1", done_cnt0 - d0); end
  endtask

  task automatic test_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    vectors++; if ({lerr0, ferr0, serr0, cnt0} !== 19'd0) begin miscompares++; $display("FAIL clear got=%b,%b,%b,%0d exp=0,0,0,0", lerr0, ferr0, serr0, cnt0); end
    vectors++; if (sum0 !== 32'd11970) begin miscompares++; $display("FAIL clear_keeps_sum got=%0d exp=11970", sum0); end
  endtask

  task automatic test_mid_sof();
    int d0 = done_cnt0;
    for (int i = 0; i < 19; i++) send_beat(0, 24'h010203, i == 0, (i % 8) == 7);
    vectors++; if ({serr0, x0, y0} !== {1'b0, 16'd3, 16'd2}) begin miscompares++; $display("FAIL pre_mid_sof got=%b,%0d,%0d exp=0,3,2", serr0, x0, y0); end
    send_beat(0, 24'h010203, 1'b1, 1'b0);
    vectors++; if ({serr0, ferr0, st0, x0, y0} !== {3'b111, 16'd1, 16'd0}) begin miscompares++; $display("FAIL mid_sof got=%b%b%b,%0d,%0d exp=111,1,0", serr0, ferr0, st0, x0, y0); end
    vectors++; if (cnt0 !== 16'd0) begin miscompares++; $display("FAIL mid_sof_count got=%0d exp=0", cnt0); end
    // Finish the restarted frame, holding clear_i on its final beat.
    for (int i = 1; i < 32; i++) begin
      if (i == 31) clear_i = 1'b1;
      send_beat(0, 24'h010203, 1'b0, (i % 8) == 7);
      clear_i = 1'b0;
    end
    vectors++; if (cnt0 !== 16'd1) begin miscompares++; $display("FAIL clear_with_done_count got=%0d exp=1", cnt0); end
    vectors++; if ({lerr0, ferr0, serr0} !== 3'b000) begin miscompares++; $display("FAIL clear_with_done_errs got=%b exp=000", {lerr0, ferr0, serr0}); end
    vectors++; if (sum0 !== 32'd192) begin miscompares++; $display("FAIL restart_sum got=%0d exp=192", sum0); end
    tick();
    vectors++; if (done_cnt0 - d0 !== 1) begin miscompares++; $display("FAIL mid_sof_done_count got=%0d exp=1", done_cnt0 - d0); end
  endtask

  task automatic test_missing_sof();
    send_beat(0, 24'h010203, 1'b0, 1'b0);
    vectors++; if ({ferr0, st0, x0, y0} !== {2'b10, 32'd0}) begin miscompares++; $display("FAIL missing_sof got=%b,%b,%0d,%0d exp=1,0,0,0", ferr0, st0, x0, y0); end
    for (int i = 1; i < 8; i++) send_beat(0, 24'h010203, 1'b0, i == 7);
    tick();
    vectors++; if (cnt0 !== 16'd1) begin miscompares++; $display("FAIL missing_sof_count got=%0d exp=1", cnt0); end
  endtask

  task automatic test_reset_mid_line();
    for (int i = 0; i < 4; i++) send_beat(0, 24'h010203, i == 0, 1'b0);
    reset_i = 1'b1;
    tick();
    vectors++; if ({if0.tready, st0, x0, y0} !== 34'd0) begin miscompares++; $display("FAIL mid_reset got=%b,%b,%0d,%0d exp=0,0,0,0", if0.tready, st0, x0, y0); end
    vectors++; if ({cnt0, ferr0} !== 17'd0) begin miscompares++; $display("FAIL mid_reset_cnt got=%0d,%b exp=0,0", cnt0, ferr0); end
    reset_i = 1'b0;
    tick();
    send_beat(0, 24'h010203, 1'b0, 1'b0);
    vectors++; if ({st0, x0, ferr0} !== 18'd0) begin miscompares++; $display("FAIL post_reset_nosof got=%b,%0d,%b exp=0,0,0", st0, x0, ferr0); end
    send_beat(0, 24'h010203, 1'b1, 1'b0);
    vectors++; if ({st0, x0, y0} !== {1'b1, 16'd1, 16'd0}) begin miscompares++; $display("FAIL post_reset_sof got=%b,%0d,%0d exp=1,1,0", st0, x0, y0); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    drive(0, 1'b0, 24'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 24'd0, 1'b0, 1'b0);
    tick();
    test_reset();
    test_clean_frame();
    test_bubbles_backpressure();
    test_early_tlast();
    test_clear();
    test_mid_sof();
    test_missing_sof();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
